// File: rtl/cheetah_pkg.sv
// Shared core definitions: datapath width, canonical NOP and fetch-queue entry layout.
package cheetah_pkg;

  localparam int unsigned XLEN = 32;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Instruction buffer between fetch and decode: first-word fall-through FIFO with
// flush, occupancy count and almost-full, emitting a NOP bubble when empty.
module fetch_queue
  import cheetah_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned AF_THRESH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Flush,
  input  logic                  enq_valid,
  output logic                  enq_ready,
  input  logic [XLEN-1:0]       enq_pc,
  input  logic [XLEN-1:0]       enq_inst,
  output logic                  deq_valid,
  input  logic                  deq_ready,
  output logic [XLEN-1:0]       deq_pc,
  output logic [XLEN-1:0]       deq_inst,
  output logic [$clog2(DEPTH):0] count,
  output logic                  almost_full
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);
  localparam logic [CntW-1:0] CntAf   = CntW'(AF_THRESH);

  fq_entry_t       mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            enq_fire, deq_fire;
  fq_entry_t       head;

  // Status is derived from registered count only, so enq_ready never depends on deq.
  always_comb begin
    enq_ready   = count_q < CntFull;
    deq_valid   = count_q != '0;
    almost_full = count_q >= CntAf;
    count       = count_q;
    enq_fire    = enq_valid & enq_ready & ~Flush;
    deq_fire    = deq_valid & deq_ready & ~Flush;
    head        = mem_q[rd_ptr_q];
    deq_pc      = '0;
    deq_inst    = NOP_INST;
    if (deq_valid) begin
      deq_pc   = head.pc;
      deq_inst = head.inst;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (Flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq_fire) wr_ptr_d = wr_ptr_q + 1'b1;
      if (deq_fire) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({enq_fire, deq_fire})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is intentionally left unreset; only entries below count are ever observed.
  always_ff @(posedge clk) begin
    if (enq_fire) mem_q[wr_ptr_q] <= '{pc: enq_pc, inst: enq_inst};
  end

  a_no_enq_when_full : assert property (@(posedge clk) disable iff (!rst)
    !(enq_fire && count_q == CntFull));
  a_no_deq_when_empty : assert property (@(posedge clk) disable iff (!rst)
    !(deq_fire && count_q == '0));
  a_count_bounded : assert property (@(posedge clk) disable iff (!rst)
    count_q <= CntFull);

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: stimulus pushes accepted entries into a reference
// FIFO; a negedge monitor compares status and pops/compares on every dequeue.
module tb_fetch_queue;
  import cheetah_pkg::*;

  localparam int unsigned DEPTH     = 4;
  localparam int unsigned AF_THRESH = 3;
  localparam int unsigned CW        = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            Flush = 1'b0;
  logic            enq_valid = 1'b0;
  logic            enq_ready;
  logic [XLEN-1:0] enq_pc = '0;
  logic [XLEN-1:0] enq_inst = '0;
  logic            deq_valid;
  logic            deq_ready = 1'b0;
  logic [XLEN-1:0] deq_pc;
  logic [XLEN-1:0] deq_inst;
  logic [CW-1:0]   count;
  logic            almost_full;

  fetch_queue #(
    .DEPTH     (DEPTH),
    .AF_THRESH (AF_THRESH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .Flush       (Flush),
    .enq_valid   (enq_valid),
    .enq_ready   (enq_ready),
    .enq_pc      (enq_pc),
    .enq_inst    (enq_inst),
    .deq_valid   (deq_valid),
    .deq_ready   (deq_ready),
    .deq_pc      (deq_pc),
    .deq_inst    (deq_inst),
    .count       (count),
    .almost_full (almost_full)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: the queue contents in order, head at index 0.
  fq_entry_t exp_q[$];
  fq_entry_t pend_entry;
  logic      pend_enq   = 1'b0;
  logic      pend_flush = 1'b0;
  logic [XLEN-1:0] next_pc = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Status and head are checked every cycle; the head is popped when decode consumes it.
  always @(negedge clk) begin
    if (rst) begin
      chk("count", 64'(count), 64'(exp_q.size()));
      chk("enq_ready", 64'(enq_ready), 64'(exp_q.size() < DEPTH));
      chk("deq_valid", 64'(deq_valid), 64'(exp_q.size() != 0));
      chk("almost_full", 64'(almost_full), 64'(exp_q.size() >= AF_THRESH));
      if (exp_q.size() != 0) begin
        chk("deq_pc", 64'(deq_pc), 64'(exp_q[0].pc));
        chk("deq_inst", 64'(deq_inst), 64'(exp_q[0].inst));
        if (deq_ready && !Flush) void'(exp_q.pop_front());
      end else begin
        chk("empty_pc", 64'(deq_pc), 64'h0);
        chk("empty_inst", 64'(deq_inst), 64'(NOP_INST));
      end
    end
  end

  task automatic commit();
    if (pend_flush) exp_q.delete();
    else if (pend_enq) exp_q.push_back(pend_entry);
    pend_enq   = 1'b0;
    pend_flush = 1'b0;
  endtask

  // One cycle: apply the previous cycle's model update at the edge, then drive new inputs.
  task automatic step(input logic ev, input logic [XLEN-1:0] pc, input logic [XLEN-1:0] inst,
                      input logic dr, input logic fl);
    @(posedge clk);
    commit();
    #1;
    enq_valid  = ev;
    enq_pc     = pc;
    enq_inst   = inst;
    deq_ready  = dr;
    Flush      = fl;
    pend_entry = '{pc: pc, inst: inst};
    pend_enq   = ev && !fl && (exp_q.size() < DEPTH);
    pend_flush = fl;
  endtask

  task automatic enq_word(input logic dr);
    step(1'b1, next_pc, $urandom, dr, 1'b0);
    next_pc += 32'h4;
  endtask

  task automatic idle(input logic dr);
    step(1'b0, '0, '0, dr, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_count"}, 64'(count), 64'h0);
    chk({tag, "_deq_valid"}, 64'(deq_valid), 64'h0);
    chk({tag, "_deq_pc"}, 64'(deq_pc), 64'h0);
    chk({tag, "_deq_inst"}, 64'(deq_inst), 64'h0000_0013);
    chk({tag, "_enq_ready"}, 64'(enq_ready), 64'h1);
    chk({tag, "_almost_full"}, 64'(almost_full), 64'h0);
  endtask

  initial begin
    #2;
    check_reset_outputs("por");
    @(negedge clk);
    #1 rst = 1'b1;

    // Fill: five offered, four accepted, almost_full from count 3.
    next_pc = '0;
    for (int i = 0; i < 5; i++) enq_word(1'b0);
    idle(1'b0);
    // Drain in order, then NOP bubble.
    for (int i = 0; i < 5; i++) idle(1'b1);

    // Simultaneous enq/deq at count 2 across pointer wrap.
    next_pc = 32'h100;
    enq_word(1'b0);
    enq_word(1'b0);
    for (int i = 0; i < 10; i++) enq_word(1'b1);
    idle(1'b0);

    // Flush at count 3 with enq and deq both presented.
    enq_word(1'b0);
    step(1'b1, 32'hdead_0000, 32'hdead_beef, 1'b1, 1'b1);
    idle(1'b0);
    step(1'b1, 32'hbad0_0000, 32'h1, 1'b1, 1'b1);
    step(1'b1, 32'hbad0_0004, 32'h2, 1'b1, 1'b1);
    idle(1'b0);

    // Full with deq: enq refused this cycle, accepted the next.
    next_pc = 32'h200;
    for (int i = 0; i < 4; i++) enq_word(1'b0);
    enq_word(1'b1);
    enq_word(1'b0);
    idle(1'b0);
    for (int i = 0; i < 6; i++) idle(1'b1);

    // Randomised traffic with phases of varying decode pressure.
    for (int i = 0; i < 3000; i++) begin
      logic ev, dr, fl;
      ev = ($urandom_range(0, 3) != 0);
      dr = (i % 600 < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      fl = ($urandom_range(0, 24) == 0);
      step(ev, next_pc, $urandom, dr, fl);
      next_pc += 32'h4;
    end

    // Asynchronous reset mid-run at count 3.
    for (int i = 0; i < 8; i++) idle(1'b1);
    for (int i = 0; i < 3; i++) enq_word(1'b0);
    idle(1'b0);
    @(posedge clk);
    commit();
    #2;
    chk("pre_reset_count", 64'(count), 64'd3);
    rst = 1'b0;
    #1;
    check_reset_outputs("async");
    exp_q.delete();
    enq_valid = 1'b0;
    deq_ready = 1'b0;
    Flush     = 1'b0;
    @(negedge clk);
    #1 rst = 1'b1;
    enq_word(1'b0);
    idle(1'b1);
    idle(1'b1);
    @(posedge clk);
    commit();
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
